// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle sequencer driving the stack data path from 8-bit instructions
// Optional CONTROL_STACK_GUARD_EN adds a stack depth guard that traps into FAULT.
module control_unit #(
    parameter int WORD_RANGE       = 8,
    parameter int PC_RANGE         = 5,
    parameter int STACK_WORD_COUNT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            instr_in,
    output logic [PC_RANGE-1:0]   pc,
    input  logic [WORD_RANGE-1:0] dp_stack_in,
    input  logic [1:0]            dp_flags_in,
    output logic [WORD_RANGE-1:0] dp_data_out,
    output logic                  dp_cache_a_b_not,
    output logic                  dp_is_data_indirect,
    output logic                  dp_aluop,
    output logic                  dp_pop_operand,
    output logic                  dp_push_result,
    output logic                  dp_write_mem_result,
    output logic [WORD_RANGE-1:0] dp_write_address,
    output logic                  halted,
    output logic                  fault
);

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_JZ   = 3'b101;
    localparam logic [2:0] OP_JN   = 3'b110;

    typedef enum logic [3:0] {
        S_FETCH, S_POP_A, S_LD_A, S_POP_B, S_LD_B,
        S_EXEC, S_STORE, S_BRANCH, S_HALT, S_FAULT
    } state_t;

    state_t                  state, state_next;
    logic [7:0]              ir;
    logic [WORD_RANGE-1:0]   operand_b;
    logic [1:0]              flags;
    logic [2:0]              ir_op;
    logic                    branch_taken;
    logic                    guard_trip;

    assign ir_op = ir[7:5];

    always_comb begin
        branch_taken = 1'b0;
        case (ir_op)
            OP_JMP:  branch_taken = 1'b1;
            OP_JZ:   branch_taken = flags[0];
            OP_JN:   branch_taken = flags[1];
            default: branch_taken = 1'b0;
        endcase
    end

`ifdef CONTROL_STACK_GUARD_EN
    localparam int DEPTH_W = $clog2(STACK_WORD_COUNT + 1);
    logic [DEPTH_W-1:0] depth;

    // Checked against the incoming instruction so a violating op never strobes.
    always_comb begin
        guard_trip = 1'b0;
        case (instr_in[7:5])
            OP_PUSH:         guard_trip = (depth == DEPTH_W'(STACK_WORD_COUNT));
            OP_POP:          guard_trip = (depth == '0);
            OP_ADD, OP_NAND: guard_trip = (depth < DEPTH_W'(2));
            default:         guard_trip = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            depth <= '0;
        else if (dp_push_result)
            depth <= depth + DEPTH_W'(1);
        else if (dp_pop_operand)
            depth <= depth - DEPTH_W'(1);
    end

    assign fault = (state == S_FAULT);
`else
    assign guard_trip = 1'b0;
    assign fault      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                case (instr_in[7:5])
                    OP_PUSH:                 state_next = S_LD_A;
                    OP_POP, OP_ADD, OP_NAND: state_next = S_POP_A;
                    OP_JMP, OP_JZ, OP_JN:    state_next = S_BRANCH;
                    default:                 state_next = S_HALT;
                endcase
                if (guard_trip)
                    state_next = S_FAULT;
            end
            S_POP_A:  state_next = S_LD_A;
            S_LD_A:   state_next = (ir_op == OP_ADD || ir_op == OP_NAND) ? S_POP_B : S_LD_B;
            S_POP_B:  state_next = S_LD_B;
            S_LD_B:   state_next = (ir_op == OP_POP) ? S_STORE : S_EXEC;
            S_EXEC:   state_next = S_FETCH;
            S_STORE:  state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            S_FAULT:  state_next = S_FAULT;
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= '0;
            ir        <= '0;
            operand_b <= '0;
            flags     <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir <= instr_in;
                    pc <= pc + PC_RANGE'(1);
                end
                S_LD_B:
                    operand_b <= (ir_op == OP_PUSH || ir_op == OP_POP) ? '0 : dp_stack_in;
                S_EXEC, S_STORE:
                    flags <= dp_flags_in;
                S_BRANCH:
                    if (branch_taken)
                        pc <= PC_RANGE'(ir[4:0]);
                default: ;
            endcase
        end
    end

    // Caches are transparent: outside LD_A keep re-driving operand_b into cache B.
    always_comb begin
        dp_cache_a_b_not    = 1'b0;
        dp_is_data_indirect = 1'b0;
        dp_data_out         = operand_b;
        dp_aluop            = 1'b0;
        dp_pop_operand      = 1'b0;
        dp_push_result      = 1'b0;
        dp_write_mem_result = 1'b0;
        case (state)
            S_LD_A: begin
                dp_cache_a_b_not = 1'b1;
                if (ir_op == OP_PUSH) begin
                    dp_is_data_indirect = 1'b1;
                    dp_data_out         = WORD_RANGE'(ir[4:0]);
                end else begin
                    dp_data_out = dp_stack_in;
                end
            end
            S_POP_A, S_POP_B: dp_pop_operand = 1'b1;
            S_EXEC: begin
                dp_push_result = 1'b1;
                dp_aluop       = ir[5];
            end
            S_STORE: dp_write_mem_result = 1'b1;
            default: ;
        endcase
    end

    assign dp_write_address = WORD_RANGE'(ir[4:0]);
    assign halted           = (state == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit with a behavioural data path and ISA model
`timescale 1ns/1ps
module tb_control_unit;
    localparam int SWC = 8;
`ifdef CONTROL_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] pc;
    logic [7:0] instr;
    logic [7:0] dp_data_out, dp_write_address;
    logic       dp_cache_a_b_not, dp_is_data_indirect, dp_aluop;
    logic       dp_pop_operand, dp_push_result, dp_write_mem_result;
    logic       halted, fault;
    logic [1:0] dp_flags = 2'b00;
    logic [7:0] stack_out = 8'h00;

    logic [7:0] imem [32];
    logic [7:0] init_mem [256];
    logic [7:0] mem [256];
    logic [7:0] mmem [256];
    logic [7:0] cache_a, cache_b, env_v, env_r;
    logic [7:0] stk [$];
    int         pushes_seen = 0, pops_seen = 0;

    ev_t        sb [$];
    int         bnd_cyc [$];
    logic [4:0] bnd_pc [$];
    int         total_cyc, exp_pops, exp_pushes;
    bit         exp_halted, exp_fault;
    int         n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;
    assign instr = imem[pc];

    control_unit #(.WORD_RANGE(8), .PC_RANGE(5), .STACK_WORD_COUNT(SWC)) dut (
        .clk(clk), .reset(rst), .instr_in(instr), .pc(pc),
        .dp_stack_in(stack_out), .dp_flags_in(dp_flags), .dp_data_out(dp_data_out),
        .dp_cache_a_b_not(dp_cache_a_b_not), .dp_is_data_indirect(dp_is_data_indirect),
        .dp_aluop(dp_aluop), .dp_pop_operand(dp_pop_operand), .dp_push_result(dp_push_result),
        .dp_write_mem_result(dp_write_mem_result), .dp_write_address(dp_write_address),
        .halted(halted), .fault(fault)
    );

    function automatic logic [7:0] bus_val();
        return dp_is_data_indirect ? mem[dp_data_out] : dp_data_out;
    endfunction

    function automatic logic [7:0] alu_res();
        logic [7:0] a, b;
        a = dp_cache_a_b_not ? bus_val() : cache_a;
        b = dp_cache_a_b_not ? cache_b : bus_val();
        return dp_aluop ? ~(a & b) : a + b;
    endfunction

    function automatic logic [1:0] fl(input logic [7:0] v);
        return {v[7], v == 8'd0};
    endfunction

    // Behavioural data path: transparent caches, LIFO stack with registered output, data memory.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] = init_mem[i];
            stk.delete();
            stack_out <= 8'h00;
            cache_a   <= 8'h00;
            cache_b   <= 8'h00;
        end else begin
            env_v = bus_val();
            env_r = alu_res();
            if (dp_cache_a_b_not) cache_a <= env_v;
            else                  cache_b <= env_v;
            if (dp_push_result) begin
                stk.push_back(env_r);
                pushes_seen++;
            end
            if (dp_pop_operand) begin
                stack_out <= (stk.size() > 0) ? stk.pop_back() : 8'h00;
                pops_seen++;
            end
            if (dp_write_mem_result) mem[dp_write_address] = env_r;
        end
    end

    always @(negedge clk) dp_flags <= fl(alu_res());

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        ev_t e, a;
        forever begin
            @(negedge clk);
            if (!rst && (dp_pop_operand || dp_push_result || dp_write_mem_result)) begin
                chk("strobe_excl", int'(dp_pop_operand) + int'(dp_push_result) + int'(dp_write_mem_result), 1);
                if (dp_push_result || dp_write_mem_result) begin
                    a.wr   = dp_write_mem_result;
                    a.addr = dp_write_mem_result ? dp_write_address : 8'h00;
                    a.val  = alu_res();
                    if (sb.size() == 0) begin
                        chk("unexpected_event", {15'd0, a.wr, a.addr, a.val}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_event", {15'd0, a.wr, a.addr, a.val}, {15'd0, e.wr, e.addr, e.val});
                    end
                end
            end
        end
    endtask

    // ISA-level reference: runs instructions on an abstract stack/memory and queues the expected events.
    task automatic model_run(input int max_instr);
        logic [7:0] s [$];
        logic [4:0] p;
        logic [1:0] f;
        logic [7:0] ir, x, y, r;
        int cyc;
        p = 5'd0; f = 2'b00; cyc = 0;
        exp_halted = 1'b0; exp_fault = 1'b0; exp_pops = 0; exp_pushes = 0;
        bnd_cyc.delete(); bnd_pc.delete();
        for (int i = 0; i < 256; i++) mmem[i] = init_mem[i];
        for (int n = 0; n < max_instr && !exp_halted && !exp_fault; n++) begin
            ir = imem[p];
            p  = p + 5'd1;
            case (ir[7:5])
                3'd0: if (GUARD && s.size() == SWC) exp_fault = 1'b1;
                      else begin
                          r = mmem[ir[4:0]]; s.push_back(r); f = fl(r);
                          sb.push_back('{1'b0, 8'h00, r}); exp_pushes++; cyc += 4;
                      end
                3'd1: if (GUARD && s.size() == 0) exp_fault = 1'b1;
                      else begin
                          x = (s.size() > 0) ? s.pop_back() : 8'h00;
                          mmem[ir[4:0]] = x; f = fl(x);
                          sb.push_back('{1'b1, {3'b000, ir[4:0]}, x}); exp_pops++; cyc += 5;
                      end
                3'd2, 3'd3: if (GUARD && s.size() < 2) exp_fault = 1'b1;
                      else begin
                          x = (s.size() > 0) ? s.pop_back() : 8'h00;
                          y = (s.size() > 0) ? s.pop_back() : 8'h00;
                          r = ir[5] ? ~(x & y) : x + y;
                          s.push_back(r); f = fl(r);
                          sb.push_back('{1'b0, 8'h00, r}); exp_pops += 2; exp_pushes++; cyc += 6;
                      end
                3'd4: begin p = ir[4:0]; cyc += 2; end
                3'd5: begin if (f[0]) p = ir[4:0]; cyc += 2; end
                3'd6: begin if (f[1]) p = ir[4:0]; cyc += 2; end
                default: begin exp_halted = 1'b1; cyc += 1; end
            endcase
            if (exp_fault) cyc += 1;
            bnd_cyc.push_back(cyc);
            bnd_pc.push_back(p);
        end
        total_cyc = cyc;
    endtask

    task automatic run_prog(input string name, input int max_instr, input bit hold);
        int base_push, base_pop, bi, d;
        rst = 1'b1;
        sb.delete();
        model_run(max_instr);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        base_push = pushes_seen;
        base_pop  = pops_seen;
        bi = 0;
        for (int k = 1; k <= total_cyc; k++) begin
            @(posedge clk); #1;
            while (bi < bnd_cyc.size() && bnd_cyc[bi] == k) begin
                chk({name, "_pc"}, pc, bnd_pc[bi]);
                bi++;
            end
        end
        @(negedge clk);
        chk({name, "_halted"}, halted, exp_halted);
        chk({name, "_fault"}, fault, exp_fault);
        chk({name, "_pushes"}, pushes_seen - base_push, exp_pushes);
        chk({name, "_pops"}, pops_seen - base_pop, exp_pops);
        chk({name, "_sb_left"}, sb.size(), 0);
        d = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== mmem[i]) d++;
        chk({name, "_mem_image"}, d, 0);
        if (!hold) rst = 1'b1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) init_mem[i] = 8'h00;
        for (int i = 0; i < 32; i++) imem[i] = 8'hE0;
    endtask

    task automatic gen_random();
        for (int i = 0; i < 256; i++) init_mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 32; i++) begin
            int k;
            logic [2:0] op;
            k  = $urandom_range(0, 15);
            op = (k < 5) ? 3'd0 : (k < 7) ? 3'd1 : (k < 9) ? 3'd2 : (k < 11) ? 3'd3 :
                 (k < 12) ? 3'd4 : (k < 13) ? 3'd5 : (k < 14) ? 3'd6 : (k == 14) ? 3'd0 : 3'd7;
            imem[i] = {op, 5'($urandom_range(0, 31))};
        end
    endtask

    initial begin
        int quiet, base_push, base_pop;
        clear_prog();
        fork
            monitor();
        join_none

        #12;
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        chk("rst_data_out", dp_data_out, 0);
        chk("rst_write_addr", dp_write_address, 0);
        chk("rst_strobes", {dp_pop_operand, dp_push_result, dp_write_mem_result,
                            dp_cache_a_b_not, dp_is_data_indirect, dp_aluop}, 0);

        clear_prog();
        init_mem[3] = 8'd5; init_mem[4] = 8'd7;
        imem[0] = 8'h03; imem[1] = 8'h04; imem[2] = 8'h40; imem[3] = 8'h25; imem[4] = 8'hA9;
        run_prog("add_prog", 5, 1'b0);
        chk("add_prog_mem5", mem[5], 8'd12);

        clear_prog();
        init_mem[1] = 8'hFF;
        imem[0] = 8'h01; imem[1] = 8'h01; imem[2] = 8'h60; imem[3] = 8'hA9;
        run_prog("nand_jz", 4, 1'b0);
        chk("nand_jz_pc9", pc, 5'd9);

        clear_prog();
        imem[0] = 8'hC2; imem[1] = 8'h9F; imem[31] = 8'hE0;
        run_prog("jn_jmp_wrap", 3, 1'b0);
        chk("wrap_pc0", pc, 5'd0);

        clear_prog();
        run_prog("halt", 1, 1'b1);
        quiet = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (dp_pop_operand || dp_push_result || dp_write_mem_result) quiet++;
        end
        chk("halt_strobes", quiet, 0);
        chk("halt_stays", halted, 1);
        rst = 1'b1; #2;
        chk("halt_rst_pc", pc, 0);
        chk("halt_rst_halted", halted, 0);

        clear_prog();
        init_mem[2] = 8'd9;
        imem[0] = 8'h02; imem[1] = 8'h02; imem[2] = 8'h40;
        run_prog("rst_mid", 2, 1'b1);
        base_push = pushes_seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_in_pop_b", dp_pop_operand, 1);
        #2;
        for (int i = 0; i < 32; i++) imem[i] = 8'hE0;
        rst = 1'b1;
        #1;
        chk("rst_mid_strobes", {dp_pop_operand, dp_push_result, dp_write_mem_result}, 0);
        chk("rst_mid_pc", pc, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_no_push", pushes_seen - base_push, 0);

        clear_prog();
        init_mem[3] = 8'd4;
        imem[0] = 8'h03; imem[1] = 8'h40;
        base_pop = pops_seen;
        run_prog("guard", 3, 1'b0);
        chk("guard_fault", fault, GUARD);
        chk("guard_pops", pops_seen - base_pop, GUARD ? 0 : 2);

        for (int t = 0; t < 4; t++) begin
            gen_random();
            run_prog("random", 30, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
